// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types for the physical register free list.
package rename_pkg;

  localparam int unsigned PHY_W     = 8;
  localparam int unsigned NUM_PHY   = 128;
  localparam int unsigned NUM_ARCH  = 32;
  localparam int unsigned NUM_PAGES = 8;

  // Encodings that never name a real physical register.
  localparam logic [PHY_W-1:0] PHY_NONE   = 8'hFF;
  localparam logic [PHY_W-1:0] PHY_UNUSED = 8'hFE;

  typedef logic [PHY_W-1:0] phy_t;

endpackage

// File: rtl/free_list_ckpt.sv
// Checkpoint store for the free-list head pointer.
// Ports: clk, reset (async active-low), wr_en_i/wr_page_i/wr_ptr_i (single write
// port), rd_page_i -> rd_ptr_o (asynchronous read port).
module free_list_ckpt #(
  parameter int unsigned NUM_PAGES = 8,
  parameter int unsigned PAGE_W    = 3,
  parameter int unsigned PTR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [PAGE_W-1:0] wr_page_i,
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic [PAGE_W-1:0] rd_page_i,
  output logic [PTR_W-1:0]  rd_ptr_o
);

  logic [PTR_W-1:0] page_q [NUM_PAGES];

  // Page register file; every page comes out of reset pointing at head 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_PAGES); i++) page_q[i] <= '0;
    end else if (wr_en_i) begin
      page_q[wr_page_i] <= wr_ptr_i;
    end
  end

  assign rd_ptr_o = page_q[rd_page_i];

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers with head-pointer checkpoints.
// Ports: clk, reset (async active-low); alloc_req -> alloc_phy/alloc_valid
// (show-ahead head entry); free_valid/free_phy return a register to the tail;
// save_state/save_page and restore_state/restore_page snapshot/roll back the
// head; count/empty/full report occupancy; overflow flags a dropped free.
module free_list
  import rename_pkg::PHY_W, rename_pkg::PHY_NONE, rename_pkg::PHY_UNUSED, rename_pkg::phy_t;
#(
  parameter int unsigned NUM_PHY   = 128,
  parameter int unsigned NUM_ARCH  = 32,
  parameter int unsigned NUM_PAGES = 8,
  localparam int unsigned PAGE_W   = $clog2(NUM_PAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  output logic [PHY_W-1:0]  alloc_phy,
  output logic              alloc_valid,
  input  logic              free_valid,
  input  logic [PHY_W-1:0]  free_phy,
  input  logic              save_state,
  input  logic [PAGE_W-1:0] save_page,
  input  logic              restore_state,
  input  logic [PAGE_W-1:0] restore_page,
  output logic [PHY_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned IDX_W = $clog2(NUM_PHY);
  localparam int unsigned PTR_W = IDX_W + 1;

  // Advance a pointer: index wraps at NUM_PHY-1 and the wrap bit toggles.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p[IDX_W-1:0] == IDX_W'(NUM_PHY - 1)) r = {~p[IDX_W], IDX_W'(0)};
    else                                      r = p + PTR_W'(1);
    return r;
  endfunction

  phy_t             mem_q [NUM_PHY];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] cnt_c;
  logic [PTR_W-1:0] ckpt_rd_c;
  logic [PTR_W-1:0] head_post_alloc_c;
  logic             do_alloc_c, do_free_c, drop_c, push_c, ckpt_we_c;

  // Occupancy is tail - head modulo 2*NUM_PHY.
  always_comb begin
    cnt_c = PTR_W'(tail_q[IDX_W-1:0]) - PTR_W'(head_q[IDX_W-1:0]);
    if (tail_q[IDX_W] != head_q[IDX_W]) cnt_c = cnt_c + PTR_W'(NUM_PHY);
  end

  assign empty       = (cnt_c == '0);
  assign full        = (cnt_c == PTR_W'(NUM_PHY));
  assign count       = PHY_W'(cnt_c);
  assign alloc_valid = !empty;
  assign alloc_phy   = empty ? PHY_NONE : mem_q[head_q[IDX_W-1:0]];
  assign overflow    = overflow_q;

  // Next-state: a restore overrides this cycle's alloc; a free is dropped only
  // when the list is still full after the alloc is accounted for.
  always_comb begin
    do_alloc_c        = alloc_req && !empty && !restore_state;
    do_free_c         = free_valid && (free_phy != PHY_NONE) && (free_phy != PHY_UNUSED);
    drop_c            = do_free_c && full && !do_alloc_c;
    push_c            = do_free_c && !drop_c;
    head_post_alloc_c = do_alloc_c ? ptr_inc(head_q) : head_q;
    ckpt_we_c         = save_state && !restore_state;
    head_d            = restore_state ? ckpt_rd_c : head_post_alloc_c;
    tail_d            = push_c ? ptr_inc(tail_q) : tail_q;
    overflow_d        = overflow_q || drop_c;
  end

  // Pointer, flag and storage registers; reset maps phys 0..NUM_ARCH-1 as in use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= PTR_W'(NUM_PHY - NUM_ARCH);
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(NUM_PHY); i++) begin
        mem_q[i] <= (i < int'(NUM_PHY - NUM_ARCH)) ? PHY_W'(NUM_ARCH + 32'(i)) : '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
      if (push_c) mem_q[tail_q[IDX_W-1:0]] <= free_phy;
    end
  end

  free_list_ckpt #(
    .NUM_PAGES (NUM_PAGES),
    .PAGE_W    (PAGE_W),
    .PTR_W     (PTR_W)
  ) u_ckpt (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ckpt_we_c),
    .wr_page_i (save_page),
    .wr_ptr_i  (head_post_alloc_c),
    .rd_page_i (restore_page),
    .rd_ptr_o  (ckpt_rd_c)
  );

endmodule

// File: tb/tb_free_list.sv
// Directed scoreboard bench for free_list with default parameters.
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req, free_valid, save_state, restore_state;
  logic [7:0] free_phy;
  logic [2:0] save_page, restore_page;
  logic [7:0] alloc_phy, count;
  logic       alloc_valid, empty, full, overflow;

  free_list dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_phy     (alloc_phy),
    .alloc_valid   (alloc_valid),
    .free_valid    (free_valid),
    .free_phy      (free_phy),
    .save_state    (save_state),
    .save_page     (save_page),
    .restore_state (restore_state),
    .restore_page  (restore_page),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  localparam int SEL_PHY = 0, SEL_CNT = 1, SEL_VLD = 2, SEL_EMP = 3, SEL_FUL = 4, SEL_OVF = 5;

  exp_t sb[$];
  int   model[$];
  bit   ovf_m;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_PHY: return 32'(alloc_phy);
      SEL_CNT: return 32'(count);
      SEL_VLD: return 32'(alloc_valid);
      SEL_EMP: return 32'(empty);
      SEL_FUL: return 32'(full);
      default: return 32'(overflow);
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] o;
      e = sb.pop_front();
      o = observe(e.sel);
      n_assert++;
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_v({tag, ":phy"}, SEL_PHY, 32'h20);
    expect_v({tag, ":vld"}, SEL_VLD, 32'd1);
    expect_v({tag, ":cnt"}, SEL_CNT, 32'd96);
    expect_v({tag, ":emp"}, SEL_EMP, 32'd0);
    expect_v({tag, ":ful"}, SEL_FUL, 32'd0);
    expect_v({tag, ":ovf"}, SEL_OVF, 32'd0);
  endtask

  task automatic model_reset();
    model.delete();
    for (int i = 0; i < 96; i++) model.push_back(32 + i);
    ovf_m = 1'b0;
  endtask

  // One cycle of alloc/free traffic checked against the FIFO model.
  task automatic step(input bit a, input bit fv, input logic [7:0] fp, input string tag);
    bit took;
    alloc_req = a; free_valid = fv; free_phy = fp;
    took = a && (model.size() > 0);
    if (took) void'(model.pop_front());
    if (fv && fp != 8'hFE && fp != 8'hFF) begin
      if (model.size() < 128) model.push_back(int'(fp));
      else ovf_m = 1'b1;
    end
    expect_v({tag, ":phy"}, SEL_PHY, (model.size() > 0) ? 32'(model[0]) : 32'hFF);
    expect_v({tag, ":cnt"}, SEL_CNT, 32'(model.size()));
    expect_v({tag, ":emp"}, SEL_EMP, 32'(model.size() == 0));
    expect_v({tag, ":ful"}, SEL_FUL, 32'(model.size() == 128));
    expect_v({tag, ":ovf"}, SEL_OVF, 32'(ovf_m));
    tick();
    check_all();
    alloc_req = 1'b0; free_valid = 1'b0; free_phy = 8'h00;
  endtask

  task automatic ctl(input bit a, input bit sv, input bit rs, input logic [2:0] sp,
                     input logic [2:0] rp, input logic [7:0] ephy, input logic [7:0] ecnt,
                     input string tag);
    alloc_req = a; save_state = sv; restore_state = rs; save_page = sp; restore_page = rp;
    expect_v({tag, ":phy"}, SEL_PHY, 32'(ephy));
    expect_v({tag, ":cnt"}, SEL_CNT, 32'(ecnt));
    tick();
    check_all();
    alloc_req = 1'b0; save_state = 1'b0; restore_state = 1'b0;
  endtask

  initial begin
    reset = 1'b0; alloc_req = 1'b0; free_valid = 1'b0; free_phy = 8'h00;
    save_state = 1'b0; restore_state = 1'b0; save_page = 3'd0; restore_page = 3'd0;
    tick();
    tick();
    expect_reset_state("rst");
    check_all();
    reset = 1'b1;

    // Three allocs from reset, then checkpoint save/restore.
    for (int k = 1; k <= 3; k++) ctl(1, 0, 0, 0, 0, 8'(8'h20 + k), 8'(96 - k), "alloc3");
    ctl(1, 0, 0, 0, 0, 8'h24, 8'd92, "alloc4");
    ctl(1, 1, 0, 3'd2, 0, 8'h25, 8'd91, "save2");
    for (int k = 1; k <= 6; k++) ctl(1, 0, 0, 0, 0, 8'(8'h25 + k), 8'(91 - k), "alloc6");
    ctl(1, 0, 1, 0, 3'd2, 8'h25, 8'd91, "restore2");
    ctl(1, 0, 0, 0, 0, 8'h26, 8'd90, "post_rst_a");
    ctl(1, 0, 0, 0, 0, 8'h27, 8'd89, "post_rst_b");
    ctl(0, 1, 1, 3'd1, 3'd2, 8'h25, 8'd91, "save_and_restore");
    ctl(0, 0, 1, 0, 3'd1, 8'h20, 8'd96, "restore1_resetval");

    // Drain the whole reset list, then alloc while empty.
    model_reset();
    for (int k = 0; k < 96; k++) step(1, 0, 8'h00, "drain");
    expect_v("drain:vld", SEL_VLD, 32'd0);
    check_all();
    step(1, 0, 8'h00, "alloc_empty");

    // Free into an empty list is not visible in the same cycle.
    alloc_req = 1'b1; free_valid = 1'b1; free_phy = 8'h05;
    #1;
    expect_v("free_empty_same:phy", SEL_PHY, 32'hFF);
    expect_v("free_empty_same:vld", SEL_VLD, 32'd0);
    check_all();
    step(1, 1, 8'h05, "free_empty_next");

    for (int j = 0; j < 9; j++) step(0, 1, 8'(8'h06 + j), "fill10");
    step(1, 1, 8'h0F, "alloc_free_10");
    step(0, 1, 8'hFE, "sentinel_fe");
    step(0, 1, 8'hFF, "sentinel_ff");

    // Fill to full across the pointer wrap, then overflow.
    for (int j = 0; j < 118; j++) step(0, 1, 8'(8'h10 + j), "fill");
    step(0, 1, 8'h99, "overflow_drop");
    step(1, 1, 8'h9A, "full_alloc_free");
    for (int k = 0; k < 128; k++) step(1, 0, 8'h00, "drain_wrap");

    // Reset in the middle of an alloc burst acts without a clock edge.
    step(0, 1, 8'h40, "pre_a");
    step(0, 1, 8'h41, "pre_b");
    step(0, 1, 8'h42, "pre_c");
    step(1, 0, 8'h00, "burst");
    alloc_req = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    expect_reset_state("async_rst");
    check_all();
    tick();
    alloc_req = 1'b0;
    reset = 1'b1;
    ctl(1, 0, 0, 0, 0, 8'h21, 8'd95, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
